// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
//   bht_state_t : 2-bit saturating direction counter encoding
//   btb_entry_t : one direct-mapped BTB line (valid, uncond, tag, target)
//   bht_step()  : saturating counter update
package branch_predictor_pkg;

    // Tag field is sized for the smallest legal BTB index (0 bits); narrower
    // tags are zero-extended so the compare stays a plain equality.
    localparam int unsigned BTB_TAG_MAX_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    typedef struct packed {
        logic                     valid;
        logic                     uncond;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
    } btb_entry_t;

    function automatic bht_state_t bht_step(input bht_state_t s, input logic taken);
        bht_state_t n;
        n = s;
        unique case (s)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Branch history table: array of 2-bit saturating counters.
//   clk, rst   : clock, asynchronous active-high reset (all counters -> WNT)
//   rd_idx     : combinational read index
//   rd_state   : counter at rd_idx (pre-update value on a same-cycle write)
//   upd_en     : apply a saturating step at upd_idx on this clock edge
//   upd_idx    : update index
//   upd_taken  : step direction (1 = towards ST)
module branch_predictor_bht_table
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_t       rd_state,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    bht_state_t cnt_q [DEPTH];

    assign rd_state = cnt_q[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= bht_step(cnt_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the 5-stage RV32I pipeline.
// IF side predicts the next PC combinationally from a tagged direct-mapped BTB
// plus a 2-bit BHT; EX side resolves the carried prediction, flags mispredicts
// and trains both tables.
//   clk, rst                 : clock, asynchronous active-high reset
//   if_pc                    : fetch PC
//   pred_taken, pred_target  : IF prediction and predicted next PC
//   ex_valid, ex_stall       : EX holds a real instruction / EX is held
//   ex_is_br, ex_is_jal      : EX instruction class
//   ex_pc, ex_br_en          : EX PC and comparator result
//   ex_target                : computed branch/jump target
//   ex_pred_taken/_target    : prediction carried down from IF
//   mispredict, redirect_pc  : flush request and correct next PC
//   br_count, miss_count     : resolved control-flow / misprediction counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned BTB_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_br,
    input  logic        ex_is_jal,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_en,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int unsigned BTB_DEPTH = 1 << BTB_IDX_W;

    btb_entry_t btb_q [BTB_DEPTH];

    logic [BHT_IDX_W-1:0]     if_bht_idx, ex_bht_idx;
    logic [BTB_IDX_W-1:0]     if_btb_idx, ex_btb_idx;
    logic [BTB_TAG_MAX_W-1:0] if_tag, ex_tag;
    bht_state_t               if_bht_state;
    btb_entry_t               if_entry;
    logic                     if_hit;
    logic [31:0]              if_pc_plus4, ex_pc_plus4;
    logic                     commit, act_taken, stale;
    logic [31:0]              act_next;
    logic                     unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_bht_idx = if_pc[BHT_IDX_W+1:2];
    assign ex_bht_idx = ex_pc[BHT_IDX_W+1:2];
    assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign if_tag     = BTB_TAG_MAX_W'(if_pc[31:BTB_IDX_W+2]);
    assign ex_tag     = BTB_TAG_MAX_W'(ex_pc[31:BTB_IDX_W+2]);

    assign if_pc_plus4 = if_pc + 32'd4;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    // ---------------- IF-side prediction ----------------
    assign if_entry = btb_q[if_btb_idx];

    always_comb begin
        if_hit      = if_entry.valid && (if_entry.tag == if_tag);
        pred_taken  = if_hit && (if_entry.uncond || if_bht_state[1]);
        pred_target = pred_taken ? if_entry.target : if_pc_plus4;
    end

    // ---------------- EX-side resolution ----------------
    // rst gating keeps the flush/redirect outputs at their reset values while
    // reset is held, even if EX inputs still look like a live mispredict.
    always_comb begin
        commit      = ex_valid && !ex_stall && !rst;
        act_taken   = ex_is_jal || (ex_is_br && ex_br_en);
        act_next    = act_taken ? ex_target : ex_pc_plus4;
        // Non-control instruction that hit a leftover BTB line.
        stale       = !ex_is_br && !ex_is_jal && ex_pred_taken;
        mispredict  = commit && ((ex_pred_taken != act_taken) ||
                                 (act_taken && (ex_pred_target != ex_target)));
        redirect_pc = rst ? ex_pc_plus4 : act_next;
    end

    // ---------------- Table updates ----------------
    branch_predictor_bht_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_bht_idx),
        .rd_state  (if_bht_state),
        .upd_en    (commit && ex_is_br),
        .upd_idx   (ex_bht_idx),
        .upd_taken (ex_br_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_q[i] <= '0;
            end
        end else if (commit) begin
            if (act_taken) begin
                btb_q[ex_btb_idx] <= '{valid:  1'b1,
                                       uncond: ex_is_jal,
                                       tag:    ex_tag,
                                       target: ex_target};
            end else if (stale) begin
                btb_q[ex_btb_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (commit && (ex_is_br || ex_is_jal)) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
